// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiters driving the mux1_2 selector.
package arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   // Same not/and decode the selector uses, so grant and mux select agree bit-for-bit.
   function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh[0] = ~idx[1] & ~idx[0];
      oh[1] = ~idx[1] &  idx[0];
      oh[2] =  idx[1] & ~idx[0];
      oh[3] =  idx[1] &  idx[0];
      return oh;
   endfunction

endpackage

// File: rtl/mux_arbiter4_rr_pick4.sv
// Round-robin search: first set request bit starting at last+1, wrapping modulo 4.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   always_comb begin
      logic [IDX_W-1:0] cand;
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = last + IDX_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin owner of the shared 4:1 select path, with optional forced release after HOLD_MAX cycles.
module mux_arbiter4
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               select1,
   output logic               select0,
   output logic               busy,
   output logic               timeout
);

   // req/gnt protocol: a requester holds req high until it sees its gnt bit, and keeps
   // it high for as long as it wants the path; dropping req releases the grant at the
   // next edge. Every output is registered, so nothing here depends combinationally on req.

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t             st_q;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   last_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic               busy_q;
   logic               timeout_q;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;

   rr_pick4 u_pick (
      .req   (req),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= ST_IDLE;
         owner_q   <= '0;
         last_q    <= 2'd3;
         cnt_q     <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (st_q)
            ST_IDLE: begin
               if (pick_found) begin
                  st_q    <= ST_GRANT;
                  owner_q <= pick_idx;
                  last_q  <= pick_idx;
                  gnt_q   <= onehot4(pick_idx);
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            ST_GRANT: begin
               if (!req[owner_q]) begin
                  st_q   <= ST_IDLE;
                  gnt_q  <= '0;
                  busy_q <= 1'b0;
               end else if ((HOLD_MAX != 0) && (cnt_q == HOLD_LAST)) begin
                  st_q      <= ST_IDLE;
                  gnt_q     <= '0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: st_q <= ST_IDLE;
         endcase
      end
   end

   // owner_q only moves on a new grant, so the mux select stays put through IDLE.
   assign select1 = owner_q[1];
   assign select0 = owner_q[0];
   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule
